// File: rtl/reorder_buffer.sv
// Four-wide reorder buffer: one row of four uops is allocated per dispatch and
// retired in order once every live entry in the head row has written back.
module reorder_buffer #(
  parameter int unsigned WIDTH_BANK = 3,
  parameter int unsigned WIDTH_REG  = 7,
  parameter int unsigned WIDTH_BRM  = 4,
  localparam int unsigned WIDTH     = 2 + 7 + 32 + WIDTH_REG + WIDTH_BRM
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_dis_we,
  input  logic [31:0]               i_dis_pc,
  input  logic [4*WIDTH-1:0]        i_dis_data4x,
  input  logic [WIDTH_BRM:0]        i_kill,
  input  logic [WIDTH_BANK+2:0]     i_rst_busy0,
  input  logic [WIDTH_BANK+2:0]     i_rst_busy1,
  input  logic [WIDTH_BANK+2:0]     i_rst_busy2,
  input  logic [WIDTH_BANK+2:0]     i_rst_busy3,
  output logic [WIDTH_BANK-1:0]     o_dis_tag,
  output logic                      o_com_en,
  output logic [4*WIDTH_REG-1:0]    o_com_prd4x
);

  localparam int unsigned DEPTH = 2 ** WIDTH_BANK;
  localparam int unsigned VAL   = WIDTH - 1;
  localparam int unsigned BUSY  = WIDTH - 2;

  logic [WIDTH-1:0]      ent_q [DEPTH][4];
  logic [WIDTH-1:0]      ent_d [DEPTH][4];
  logic [31:0]           pc_q  [DEPTH];
  logic [WIDTH_BANK-1:0] head_q, tail_q;
  logic [WIDTH_BANK:0]   count_q, count_d;
  logic [DEPTH-1:0]      occ;
  logic [WIDTH_BANK+2:0] wb [4];
  logic                  dis_acc;

  function automatic logic is_killed(input logic [WIDTH-1:0] e, input logic [WIDTH_BRM:0] kill);
    return kill[WIDTH_BRM] && (|(e[WIDTH_BRM-1:0] & kill[WIDTH_BRM-1:0]));
  endfunction

  assign wb[0] = i_rst_busy0;
  assign wb[1] = i_rst_busy1;
  assign wb[2] = i_rst_busy2;
  assign wb[3] = i_rst_busy3;

  assign o_dis_tag = tail_q;

  // A row is occupied when its distance from head is below count.
  always_comb begin
    occ = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      occ[r] = {1'b0, WIDTH_BANK'(r) - head_q} < count_q;
    end
  end

  always_comb begin
    o_com_en    = (count_q != '0);
    o_com_prd4x = '0;
    for (int l = 0; l < 4; l++) begin
      if (ent_q[head_q][l][VAL] && ent_q[head_q][l][BUSY]) o_com_en = 1'b0;
      if (ent_q[head_q][l][VAL]) begin
        o_com_prd4x[l*WIDTH_REG +: WIDTH_REG] = ent_q[head_q][l][WIDTH_BRM +: WIDTH_REG];
      end
    end
  end

  // When full, a same-cycle commit frees the head slot that tail points at.
  assign dis_acc = i_dis_we && ((count_q != (WIDTH_BANK+1)'(DEPTH)) || o_com_en);

  always_comb begin
    ent_d = ent_q;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      for (int l = 0; l < 4; l++) begin
        if (occ[r] && is_killed(ent_q[r][l], i_kill)) ent_d[r][l][VAL] = 1'b0;
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (wb[p][WIDTH_BANK+2] && occ[wb[p][WIDTH_BANK+1:2]]) begin
        ent_d[wb[p][WIDTH_BANK+1:2]][wb[p][1:0]][BUSY] = 1'b0;
      end
    end
    if (o_com_en) begin
      for (int l = 0; l < 4; l++) ent_d[head_q][l][VAL] = 1'b0;
    end
    // Dispatch goes last so it overrides anything aimed at the stale tail slot.
    if (dis_acc) begin
      for (int l = 0; l < 4; l++) begin
        ent_d[tail_q][l] = i_dis_data4x[l*WIDTH +: WIDTH];
        if (is_killed(i_dis_data4x[l*WIDTH +: WIDTH], i_kill)) ent_d[tail_q][l][VAL] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (dis_acc && !o_com_en) begin
      count_d = count_q + 1'b1;
    end else if (!dis_acc && o_com_en) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
        pc_q[r] <= '0;
        for (int l = 0; l < 4; l++) ent_q[r][l] <= '0;
      end
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      if (dis_acc) begin
        pc_q[tail_q] <= i_dis_pc;
        tail_q       <= tail_q + 1'b1;
      end
      if (o_com_en) head_q <= head_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a row-level scoreboard that predicts
// tags, commit timing and retired prd values.
module tb_reorder_buffer;

  localparam int W = 52;

  typedef struct packed {
    logic [27:0] prd;
    logic [15:0] brm;
    logic [3:0]  val;
    logic [3:0]  busy;
  } row_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          dis_we;
  logic [31:0]   dis_pc;
  logic [4*W-1:0] dis_data;
  logic [4:0]    kill;
  logic [5:0]    rb [4];
  logic [2:0]    o_dis_tag;
  logic          o_com_en;
  logic [27:0]   o_com_prd4x;

  int   checks = 0;
  int   errors = 0;
  row_t q[$];
  row_t pend;
  int   head_m = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_dis_we     (dis_we),
    .i_dis_pc     (dis_pc),
    .i_dis_data4x (dis_data),
    .i_kill       (kill),
    .i_rst_busy0  (rb[0]),
    .i_rst_busy1  (rb[1]),
    .i_rst_busy2  (rb[2]),
    .i_rst_busy3  (rb[3]),
    .o_dis_tag    (o_dis_tag),
    .o_com_en     (o_com_en),
    .o_com_prd4x  (o_com_prd4x)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int tail_m();
    return (head_m + q.size()) % 8;
  endfunction

  task automatic defaults();
    rst = 1'b0; dis_we = 1'b0; dis_pc = '0; dis_data = '0; kill = '0;
    for (int p = 0; p < 4; p++) rb[p] = '0;
  endtask

  task automatic set_row(input logic [27:0] prd, input logic [15:0] brm,
                         input logic [3:0] val, input logic [3:0] busy);
    dis_we = 1'b1;
    dis_pc = $urandom;
    for (int k = 0; k < 4; k++) begin
      dis_data[k*W +: W] = {val[k], busy[k], 7'($urandom), 32'($urandom),
                            prd[k*7 +: 7], brm[k*4 +: 4]};
    end
    pend = '{prd: prd, brm: brm, val: val, busy: busy};
  endtask

  task automatic wb_port(input int p, input int row, input int lane);
    rb[p] = {1'b1, 3'(row), 2'(lane)};
  endtask

  task automatic clear_row(input int row);
    for (int k = 0; k < 4; k++) wb_port(k, row, k);
  endtask

  // Check outputs against the model, advance the model, then take one edge.
  task automatic step();
    row_t f, t;
    logic mc;
    logic [27:0] ep;
    logic acc;
    int idx;
    mc = 1'b0;
    ep = '0;
    if (q.size() > 0) begin
      f  = q[0];
      mc = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (f.val[k] && f.busy[k]) mc = 1'b0;
        if (f.val[k]) ep[k*7 +: 7] = f.prd[k*7 +: 7];
      end
    end
    chk("dis_tag", 32'(o_dis_tag), 32'(tail_m()));
    chk("com_en", 32'(o_com_en), 32'(mc));
    if (mc) chk("com_prd", 32'(o_com_prd4x), 32'(ep));
    if (rst) begin
      q.delete();
      head_m = 0;
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        t = q[i];
        for (int k = 0; k < 4; k++)
          if (kill[4] && (|(t.brm[k*4 +: 4] & kill[3:0]))) t.val[k] = 1'b0;
        q[i] = t;
      end
      for (int p = 0; p < 4; p++) begin
        if (rb[p][5]) begin
          idx = (int'(rb[p][4:2]) - head_m + 8) % 8;
          if (idx < q.size()) begin
            t = q[idx];
            t.busy[rb[p][1:0]] = 1'b0;
            q[idx] = t;
          end
        end
      end
      acc = dis_we && (q.size() < 8 || mc);
      if (mc) begin
        void'(q.pop_front());
        head_m = (head_m + 1) % 8;
      end
      if (acc) begin
        t = pend;
        for (int k = 0; k < 4; k++)
          if (kill[4] && (|(t.brm[k*4 +: 4] & kill[3:0]))) t.val[k] = 1'b0;
        q.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    defaults();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      clear_row(head_m);
      step();
      guard++;
    end
    step();
  endtask

  int prev;

  initial begin
    defaults();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    defaults();
    chk("rst_prd", 32'(o_com_prd4x), 32'h0);
    chk("rst_tag", 32'(o_dis_tag), 32'h0);
    chk("rst_com", 32'(o_com_en), 32'h0);

    // Single row, cleared via all four writeback ports.
    set_row({7'd3, 7'd2, 7'd1, 7'd0}, 16'h0, 4'hf, 4'hf);
    step();
    step();
    clear_row(0);
    step();
    chk("basic_prd", 32'(o_com_prd4x), 32'({7'h3, 7'h2, 7'h1, 7'h0}));
    step();
    step();

    // Fill to capacity; extra dispatches are dropped.
    rst = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      set_row(28'($urandom), 16'h0, 4'hf, 4'hf);
      step();
    end
    clear_row(0);
    step();
    set_row(28'($urandom), 16'h0, 4'hf, 4'hf);
    step();
    set_row(28'($urandom), 16'h0, 4'hf, 4'hf);
    step();
    drain();

    // Branch kill on resident rows and on the row dispatched in the same cycle.
    prev = tail_m();
    set_row({7'd13, 7'd12, 7'd11, 7'd10}, 16'h2121, 4'hf, 4'hf);
    step();
    set_row({7'd23, 7'd22, 7'd21, 7'd20}, 16'h1111, 4'hf, 4'hf);
    step();
    kill = 5'b1_0001;
    set_row({7'd33, 7'd32, 7'd31, 7'd30}, 16'h2221, 4'hf, 4'hf);
    step();
    wb_port(0, prev, 1);
    wb_port(1, prev, 3);
    step();
    chk("kill_prd", 32'(o_com_prd4x), 32'({7'd13, 7'd0, 7'd11, 7'd0}));
    step();
    step();
    drain();

    // Twenty rows with wrap-around; some dispatch already complete.
    prev = -1;
    for (int i = 0; i < 20; i++) begin
      set_row(28'($urandom), 16'h0, 4'($urandom), (i % 3 == 0) ? 4'h0 : 4'hf);
      if (prev >= 0) clear_row(prev);
      prev = tail_m();
      step();
    end
    drain();

    // All four ports aimed at one entry.
    prev = tail_m();
    set_row(28'($urandom), 16'h0, 4'hf, 4'h4);
    step();
    step();
    for (int p = 0; p < 4; p++) wb_port(p, prev, 2);
    step();
    step();
    step();

    // Reset in the middle of operation discards everything.
    for (int i = 0; i < 3; i++) begin
      set_row(28'($urandom), 16'h0, 4'hf, 4'hf);
      step();
    end
    rst = 1'b1;
    step();
    chk("midrst_prd", 32'(o_com_prd4x), 32'h0);
    set_row({7'd44, 7'd43, 7'd42, 7'd41}, 16'h0, 4'hf, 4'h0);
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Four-wide, bank-interleaved reorder buffer for the out-of-order core. Each dispatch cycle allocates one row of four uop entries at the tail and returns the row tag. Writeback ports clear per-entry busy bits, and a branch kill invalidates speculative entries. The oldest row retires in order once all four entries are done, releasing their destination physical registers to the free list.

## Interface
Parameters:
- WIDTH_BANK, 3: row-index width; depth = 2^WIDTH_BANK rows of 4 entries.
- WIDTH_REG, 7: physical register index width.
- WIDTH_BRM, 4: branch-mask width.
- WIDTH (derived), 2+7+32+WIDTH_REG+WIDTH_BRM: entry width.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- i_clk, in, 1: clock; all state updates on rising edge.
- i_rst, in, 1: synchronous active-high reset.
- i_dis_we, in, 1: dispatch request for one row.
- i_dis_pc, in, 32: PC of lane 0 of the dispatched row.
- i_dis_data4x, in, 4*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH]. Each entry is, MSB to LSB: {val, busy, uop[6:0], imm[31:0], prd[WIDTH_REG-1:0], brm[WIDTH_BRM-1:0]}.
- i_kill, in, WIDTH_BRM+1: bit WIDTH_BRM is the enable; the low bits are the branch mask.
- i_rst_busy0..3, in, 1+WIDTH_BANK+2 each: {en, row[WIDTH_BANK-1:0], lane[1:0]} clears one entry's busy bit.
- o_dis_tag, out, WIDTH_BANK: current tail row index, i.e. the tag given to the row dispatched this cycle.
- o_com_en, out, 1: head row retires this cycle.
- o_com_prd4x, out, 4*WIDTH_REG: prd of head lanes 0..3 at [k*WIDTH_REG +:]. A lane with val=0 outputs 0.

## Operation
State:
- Per row: 4 entry registers and a 32-bit PC.
- head and tail pointers, WIDTH_BANK bits each.
- count, WIDTH_BANK+1 bits.

Reset:
- head = tail = count = 0.
- All entry bits and PCs = 0.

Dispatch:
- Accepted when i_dis_we=1 and either count < 2^WIDTH_BANK or a commit occurs in the same cycle.
- On accept: write the 4 lanes and PC to row tail; tail = tail+1 (wraps modulo depth).
- When full with no commit, the request is dropped silently and tail is unchanged. The upstream stage stalls using its own occupancy tracking.

Writeback:
- For each port with en=1, clear busy of entry (row, lane).
- The four ports are independent and may target the same entry.
- A port targeting a row outside the occupied range is ignored.

Kill:
- When i_kill[WIDTH_BRM]=1, every occupied entry with (brm & mask) != 0 gets val=0.
- The same test applies to lanes being dispatched that cycle.
- Killed entries stay in their row until it retires.

Commit:
- Condition: count>0 and every head-row entry has val=0 or busy=0.
- o_com_en is combinational from state. On the clock edge while asserted: head = head+1 (wraps), and the row's val bits are cleared.
- Exactly one row retires per cycle, in program order.

Count update:
- count +1 on dispatch only, -1 on commit only, unchanged on both or neither.

PC:
- Stored per row for exception redirect. It has no readout port in this revision.

Priority within one cycle:
- Dispatch write to row tail overrides writeback or kill bits aimed at that stale slot.
- Kill and writeback on different entries both apply.

## Timing
- o_dis_tag is valid combinationally during the dispatch cycle; it reflects tail before the edge.
- A busy clear at edge N makes the entry complete from cycle N+1.
- If that completes the head row, o_com_en=1 in cycle N+1 and head advances at edge N+1. Minimum dispatch-to-commit latency is 1 cycle (row dispatched already done).
- Outputs after reset: o_dis_tag=0, o_com_en=0, o_com_prd4x=0.
- Reset asserted mid-operation discards all rows on that edge.
- Wrap-around: with depth 8, tail goes 7 -> 0; full is count=8 with head==tail, empty is count=0 with head==tail.

## Test plan
- Reset, then dispatch one row with lanes val=1, busy=1, prd 0..3 -> o_dis_tag=0; next cycle o_dis_tag=1, o_com_en=0.
- Clear busy of row 0 lanes 0..3 via i_rst_busy0..3 = {1,3'h0,2'bkk} -> next cycle o_com_en=1, o_com_prd4x={7'h3,7'h2,7'h1,7'h0}; head advances to 1.
- Dispatch continuously with busy never cleared -> o_dis_tag counts 0..7. After 8 rows, further dispatches are dropped and the tag holds at 0 (tail == head).
- With the buffer full, clear row 0 while dispatching -> commit and dispatch occur on the same edge and count stays 8.
- Kill with mask 4'b0001 while rows hold brm=0001 and 0010 -> brm=0001 entries become val=0; their lanes retire with prd output 0 once the 0010 lanes finish.
- Full wrap-around over 20 rows with in-order clears -> tags wrap 7 -> 0 and commits appear in dispatch order with the correct prd values.
